riscv_dmem_responder: RTL and testbench

- Data-memory target that answers the load/store requests issued by the RISC-V core.
- Single outstanding transaction, request/response valid-ready handshake, configurable wait-state latency, byte-enable writes.
- Used as the data-side memory model and target in core-level benches and in the multi-cycle core build.

---
 rtl/riscv_dmem_pkg.sv | 13 +
 rtl/riscv_dmem_array.sv | 33 +++
 rtl/riscv_dmem_responder.sv | 143 ++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the RISC-V data-memory responder.
package riscv_dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int BE_W       = 4;
  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;
  localparam int PERF_W     = 16;
endpackage

// File: rtl/riscv_dmem_array.sv
// Single-port synchronous byte-enable RAM, DEPTH_WORDS x 32, no reset.
module riscv_dmem_array
  import riscv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [BE_W-1:0] be_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read data is only refreshed by a load, so it stays stable while a response is held.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory target: one outstanding load/store, LATENCY wait states, byte-enable writes.
// Define RISCV_DMEM_PERF_EN to add saturating load/store/error response counters.
module riscv_dmem_responder
  import riscv_dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef RISCV_DMEM_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores,
  output logic [PERF_W-1:0] perf_errs
`endif
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmem_state_e       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, err_q, load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              accept, enter_resp;
  logic              cur_we, cur_err;
  logic [ADDR_W-1:0] cur_addr, cur_idx;
  logic [31:0]       cur_wdata, ram_rdata;
  logic [BE_W-1:0]   cur_be;

  assign req_ready = (state_q == IDLE) && !srst;
  assign accept    = req_valid && req_ready;

  // With zero latency the access happens on the accept edge, so use the live request.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;
  assign cur_idx   = cur_addr >> 2;
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_idx >= ADDR_W'(DEPTH_WORDS));

  assign enter_resp = (LATENCY == 0) ? accept
                                     : ((state_q == WAIT) && (cnt_q == '0) && !srst);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 0) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else cnt_d = cnt_q - 1'b1;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        err_q  <= cur_err;
        load_q <= !cur_we && !cur_err;
      end
    end
  end

  riscv_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .en_i    (enter_resp && !cur_err),
    .we_i    (cur_we),
    .addr_i  (cur_idx[AW-1:0]),
    .be_i    (cur_be),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q) ? ram_rdata : 32'h0;

`ifdef RISCV_DMEM_PERF_EN
  logic [PERF_W-1:0] loads_q, stores_q, errs_q;
  logic              rsp_hs;

  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (rsp_hs) begin
      if (err_q) begin
        if (errs_q != '1) errs_q <= errs_q + 1'b1;
      end else if (we_q) begin
        if (stores_q != '1) stores_q <= stores_q + 1'b1;
      end else begin
        if (loads_q != '1) loads_q <= loads_q + 1'b1;
      end
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errs   = errs_q;
`endif
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench: two responders (LATENCY 2 and 0) checked against a word-array reference model.
module tb_riscv_dmem_responder;
  logic clk = 1'b0;
  logic srst;
  logic [1:0]       req_valid, req_we, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_be;
  wire  [1:0]       req_ready, rsp_valid, rsp_err;
  wire  [1:0][31:0] rsp_rdata;
`ifdef RISCV_DMEM_PERF_EN
  wire  [1:0][15:0] perf_loads, perf_stores, perf_errs;
`endif

  always #5 clk = ~clk;

  riscv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .srst(srst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef RISCV_DMEM_PERF_EN
    , .perf_loads(perf_loads[0]), .perf_stores(perf_stores[0]), .perf_errs(perf_errs[0])
`endif
  );

  riscv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
    .clk(clk), .srst(srst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef RISCV_DMEM_PERF_EN
    , .perf_loads(perf_loads[1]), .perf_stores(perf_stores[1]), .perf_errs(perf_errs[1])
`endif
  );

  int passed = 0;
  int total  = 0;
  int LATV [2] = '{2, 0};

  // Reference: plain word array per instance plus expected response-kind tallies.
  logic [31:0] mdl [2][256];
  int pl [2], ps [2], pe [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model(input int u, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output bit er);
    int unsigned w;
    w  = a / 4;
    er = (a % 4 != 0) || (w >= 256);
    rd = 32'h0;
    if (er) pe[u]++;
    else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[u][w][8*b +: 8] = d[8*b +: 8];
      ps[u]++;
    end else begin
      rd = mdl[u][w];
      pl[u]++;
    end
  endtask

  task automatic scramble(input int u);
    req_we[u]    = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_be[u]    = 4'($urandom);
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the handshake edge.
  task automatic txn(input int u, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input string tag);
    logic [31:0] erd;
    bit          eer;
    int          n, lat;
    model(u, we, a, d, be, erd, eer);
    req_we[u] = we; req_addr[u] = a; req_wdata[u] = d; req_be[u] = be;
    req_valid[u] = 1'b1; rsp_ready[u] = 1'b1;
    n = 0;
    while (!req_ready[u] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    scramble(u);
    lat = 1;
    while (!rsp_valid[u] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(LATV[u] + 1));
    chk({tag, " rdata"}, rsp_rdata[u], erd);
    chk({tag, " err"}, 32'(rsp_err[u]), 32'(eer));
    @(posedge clk); #1;
    chk({tag, " rsp_valid drop"}, 32'(rsp_valid[u]), 32'h0);
  endtask

  initial begin
    logic [31:0] erd, held, a;
    bit          eer;
    int          hs;
    srst = 1'b1;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    for (int u = 0; u < 2; u++) begin pl[u] = 0; ps[u] = 0; pe[u] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset req_ready", 32'(req_ready[u]), 32'h0);
      chk("reset rsp_valid", 32'(rsp_valid[u]), 32'h0);
      chk("reset rsp_rdata", rsp_rdata[u], 32'h0);
      chk("reset rsp_err", 32'(rsp_err[u]), 32'h0);
    end
    srst = 1'b0;
    #1;
    chk("post-reset req_ready l2", 32'(req_ready[0]), 32'h1);
    chk("post-reset req_ready l0", 32'(req_ready[1]), 32'h1);
    @(posedge clk); #1;

    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++) txn(u, 1'b1, 32'(w * 4), $urandom, 4'hF, "init store");

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "full store");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "load back");
    chk("load back const", mdl[0][4], 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, "byte store");
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, "byte load");
    chk("byte merge const", mdl[0][4], 32'hDEADBEAA);
    txn(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, "be0 store");
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, "be0 load");
    txn(0, 1'b0, 32'h12, 32'h0, 4'hF, "misaligned load");
    txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, "oob store");
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, "no wrap load");

    // Backpressure: response held for 5 cycles while a second request waits.
    model(0, 1'b0, 32'h10, 32'h0, 4'hF, erd, eer);
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_addr[0] = 32'h14;
    hs = 0;
    while (!rsp_valid[0] && hs < 50) begin @(posedge clk); #1; hs++; end
    chk("bp rdata", rsp_rdata[0], erd);
    held = rsp_rdata[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'h1);
      chk("bp rdata stable", rsp_rdata[0], held);
      chk("bp req_ready low", 32'(req_ready[0]), 32'h0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp released rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("bp idle req_ready", 32'(req_ready[0]), 32'h1);
    model(0, 1'b0, 32'h14, 32'h0, 4'hF, erd, eer);
    @(posedge clk); #1;
    chk("bp second accepted", 32'(req_ready[0]), 32'h0);
    req_valid[0] = 1'b0;
    hs = 0;
    while (!rsp_valid[0] && hs < 50) begin @(posedge clk); #1; hs++; end
    chk("bp second rdata", rsp_rdata[0], erd);
    @(posedge clk); #1;

    // Zero latency: single load, then continuous requests.
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, "l0 load");
    req_we[1] = 1'b0; req_addr[1] = 32'h0; req_be[1] = 4'hF;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) begin
        hs++;
        chk("l0 stream rdata", rsp_rdata[1], mdl[1][0]);
      end
    end
    req_valid[1] = 1'b0;
    pl[1] += hs;
    chk("l0 throughput", 32'(hs), 32'd10);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++)
      for (int u = 0; u < 2; u++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
          1:       a = 32'h400 + 32'($urandom_range(0, 4000) * 4);
          default: a = 32'($urandom_range(0, 15) * 4);
        endcase
        txn(u, 1'($urandom), a, $urandom, 4'($urandom), "random");
      end

    // Reset during WAIT aborts the store; perf counters restart from zero.
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    srst = 1'b1;
    #1;
    chk("abort rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("abort rsp_rdata", rsp_rdata[0], 32'h0);
    chk("abort rsp_err", 32'(rsp_err[0]), 32'h0);
    chk("abort req_ready", 32'(req_ready[0]), 32'h0);
    @(posedge clk); #1;
    srst = 1'b0;
    for (int u = 0; u < 2; u++) begin pl[u] = 0; ps[u] = 0; pe[u] = 0; end
    @(posedge clk); #1;
    chk("abort no late rsp", 32'(rsp_valid[0]), 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, "abort load prior");
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, "perf load");
    txn(0, 1'b1, 32'h30, 32'h0BADF00D, 4'h3, "perf store");
    txn(0, 1'b0, 32'h12, 32'h0, 4'hF, "perf err");
`ifdef RISCV_DMEM_PERF_EN
    chk("perf loads", 32'(perf_loads[0]), 32'(pl[0]));
    chk("perf stores", 32'(perf_stores[0]), 32'(ps[0]));
    chk("perf errs", 32'(perf_errs[0]), 32'(pe[0]));
    chk("perf l0 loads", 32'(perf_loads[1]), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
